// File: rtl/wallace_mac_pipe.sv
// Three-stage Baugh-Wooley / Wallace-tree multiply-accumulate with a global-stall valid/ready pipeline.
// S1 forms and partially reduces the partial products, S2 finishes the carry-save tree, S3 adds and accumulates.
module wallace_mac_pipe #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 24,
   parameter bit SATURATE  = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_in,
   input  logic                 acc_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 out_ovf
);

   localparam int PW  = 2 * WIDTH;
   localparam int AW1 = ACC_WIDTH + 1;
   localparam int R0  = WIDTH + 1;
   localparam int R1  = 2 * (R0 / 3) + (R0 % 3);

   function automatic int rows_after(input int start, input int layers);
      int n;
      n = start;
      for (int l = 0; l < layers; l++) begin
         if (n > 2) n = 2 * (n / 3) + (n % 3);
      end
      return n;
   endfunction

   function automatic int layers_to_two(input int start);
      int n;
      int l;
      n = start;
      l = 0;
      while (n > 2) begin
         n = 2 * (n / 3) + (n % 3);
         l = l + 1;
      end
      return l;
   endfunction

   function automatic logic [PW-1:0] maj_shift(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                               input logic [PW-1:0] z);
      return ((x & y) | (x & z) | (y & z)) << 1;
   endfunction

   localparam int NL = layers_to_two(R1);

   logic                 adv;
   logic                 s1_valid_q, s1_signed_q, s1_acc_q;
   logic [PW-1:0]        s1_rows_q [R1];
   logic [PW-1:0]        s1_rows_d [R1];
   logic                 s2_valid_q, s2_signed_q, s2_acc_q;
   logic [PW-1:0]        s2_sum_q, s2_carry_q;
   logic [PW-1:0]        s2_sum_d, s2_carry_d;
   logic                 out_valid_q, ovf_q;
   logic [ACC_WIDTH-1:0] acc_q;

   // Valid/ready: a beat enters on in_valid & in_ready and leaves on out_valid & out_ready. The whole pipe
   // advances together whenever the output register is empty or being drained, so bubbles are kept in place.
   assign adv       = !out_valid_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_data  = acc_q;
   assign out_ovf   = ovf_q;

   // Row WIDTH carries the Baugh-Wooley correction ones at columns WIDTH and 2*WIDTH-1.
   logic [PW-1:0] pp [R0];
   always_comb begin
      for (int i = 0; i < R0; i++) pp[i] = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pp[i][i+j] = (a[j] & b[i]) ^ (signed_in & ((i == WIDTH - 1) != (j == WIDTH - 1)));
         end
      end
      if (signed_in) begin
         pp[WIDTH][WIDTH] = 1'b1;
         pp[WIDTH][PW-1]  = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < R1; i++) s1_rows_d[i] = '0;
      for (int g = 0; g < R0 / 3; g++) begin
         s1_rows_d[2*g]   = pp[3*g] ^ pp[3*g+1] ^ pp[3*g+2];
         s1_rows_d[2*g+1] = maj_shift(pp[3*g], pp[3*g+1], pp[3*g+2]);
      end
      for (int k = 0; k < R0 % 3; k++) s1_rows_d[2*(R0/3)+k] = pp[3*(R0/3)+k];
   end

   // Remaining 3:2 layers; each layer's row count is fixed by the parameters.
   logic [PW-1:0] lay [NL+1][R1];
   for (genvar r = 0; r < R1; r++) begin : g_lay0
      assign lay[0][r] = s1_rows_q[r];
   end
   for (genvar l = 0; l < NL; l++) begin : g_layer
      localparam int N  = rows_after(R1, l);
      localparam int G  = N / 3;
      localparam int NN = 2 * G + (N % 3);
      for (genvar g = 0; g < G; g++) begin : g_csa
         assign lay[l+1][2*g]   = lay[l][3*g] ^ lay[l][3*g+1] ^ lay[l][3*g+2];
         assign lay[l+1][2*g+1] = maj_shift(lay[l][3*g], lay[l][3*g+1], lay[l][3*g+2]);
      end
      for (genvar k = 0; k < N % 3; k++) begin : g_pass
         assign lay[l+1][2*G+k] = lay[l][3*G+k];
      end
      for (genvar r = NN; r < R1; r++) begin : g_zero
         assign lay[l+1][r] = '0;
      end
   end
   assign s2_sum_d   = lay[NL][0];
   assign s2_carry_d = lay[NL][1];

   logic [PW-1:0]        prod;
   logic [AW1-1:0]       prod_x, acc_x, sum;
   logic                 ovf_d;
   logic [ACC_WIDTH-1:0] sat_val, acc_d;
   always_comb begin
      prod    = s2_sum_q + s2_carry_q;
      prod_x  = {{(AW1 - PW){s2_signed_q & prod[PW-1]}}, prod};
      acc_x   = {s2_signed_q & acc_q[ACC_WIDTH-1], acc_q};
      sum     = prod_x + (s2_acc_q ? acc_x : '0);
      ovf_d   = s2_signed_q ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
      sat_val = s2_signed_q ? {sum[ACC_WIDTH], {(ACC_WIDTH - 1){~sum[ACC_WIDTH]}}} : {ACC_WIDTH{1'b1}};
      acc_d   = (SATURATE && ovf_d) ? sat_val : sum[ACC_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_signed_q <= 1'b0;
         s1_acc_q    <= 1'b0;
         for (int i = 0; i < R1; i++) s1_rows_q[i] <= '0;
         s2_valid_q  <= 1'b0;
         s2_signed_q <= 1'b0;
         s2_acc_q    <= 1'b0;
         s2_sum_q    <= '0;
         s2_carry_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         acc_q       <= '0;
      end else if (adv) begin
         s1_valid_q  <= in_valid;
         s1_signed_q <= signed_in;
         s1_acc_q    <= acc_in;
         s1_rows_q   <= s1_rows_d;
         s2_valid_q  <= s1_valid_q;
         s2_signed_q <= s1_signed_q;
         s2_acc_q    <= s1_acc_q;
         s2_sum_q    <= s2_sum_d;
         s2_carry_q  <= s2_carry_d;
         out_valid_q <= s2_valid_q;
         // Only a real beat entering S3 touches the accumulator.
         if (s2_valid_q) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_wallace_mac_pipe.sv
// Bench for wallace_mac_pipe: five differently parameterised instances driven in lockstep and
// checked every cycle against an arithmetic model, plus hand-computed literal results.
module tb_wallace_mac_pipe;

   typedef logic [4:0][32:0] beat_t;

   localparam int CW   [5] = '{8, 8, 8, 4, 16};
   localparam int CAW  [5] = '{24, 16, 16, 8, 32};
   localparam int CSAT [5] = '{1, 1, 0, 0, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, signed_in, acc_in, out_ready;
   logic [15:0] a, b;
   logic        rdy0, rdy1, rdy2, rdy3, rdy4;
   logic        ov0, ov1, ov2, ov3, ov4;
   logic        of0, of1, of2, of3, of4;
   logic [23:0] od0;
   logic [15:0] od1, od2;
   logic [7:0]  od3;
   logic [31:0] od4;

   always #5 clk = ~clk;

   wallace_mac_pipe #(.WIDTH(8), .ACC_WIDTH(24), .SATURATE(1'b1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .a(a[7:0]), .b(b[7:0]),
      .signed_in(signed_in), .acc_in(acc_in), .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0), .out_ovf(of0));
   wallace_mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b1)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .a(a[7:0]), .b(b[7:0]),
      .signed_in(signed_in), .acc_in(acc_in), .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1), .out_ovf(of1));
   wallace_mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .SATURATE(1'b0)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .a(a[7:0]), .b(b[7:0]),
      .signed_in(signed_in), .acc_in(acc_in), .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2), .out_ovf(of2));
   wallace_mac_pipe #(.WIDTH(4), .ACC_WIDTH(8), .SATURATE(1'b0)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .a(a[3:0]), .b(b[3:0]),
      .signed_in(signed_in), .acc_in(acc_in), .out_valid(ov3), .out_ready(out_ready),
      .out_data(od3), .out_ovf(of3));
   wallace_mac_pipe #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b1)) u4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b),
      .signed_in(signed_in), .acc_in(acc_in), .out_valid(ov4), .out_ready(out_ready),
      .out_data(od4), .out_ovf(of4));

   beat_t act;
   always_comb begin
      act[0] = {of0, 8'b0, od0};
      act[1] = {of1, 16'b0, od1};
      act[2] = {of2, 16'b0, od2};
      act[3] = {of3, 24'b0, od3};
      act[4] = {of4, od4};
   end

   longint macc [5];
   beat_t  exp_q[$];
   beat_t  got_q[$];
   int     n_cmp;
   int     n_bad;
   bit     ok_b;

   task automatic chk(input string name, input longint got, input longint want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   // Plain-integer MAC: interpret operands and stored accumulator under this beat's mode,
   // add exactly, then clamp or wrap to the instance's accumulator range.
   function automatic logic [32:0] model_step(input int k, input logic [15:0] av, input logic [15:0] bv,
                                              input bit sg, input bit ac);
      longint one, w, aw, ca, cb, accv, sum, lo, hi, mask;
      bit ovf;
      one  = 1;
      w    = CW[k];
      aw   = CAW[k];
      mask = (one << aw) - 1;
      ca   = longint'(av) & ((one << w) - 1);
      cb   = longint'(bv) & ((one << w) - 1);
      if (sg && ca >= (one << (w - 1))) ca = ca - (one << w);
      if (sg && cb >= (one << (w - 1))) cb = cb - (one << w);
      accv = macc[k];
      if (sg && accv >= (one << (aw - 1))) accv = accv - (one << aw);
      sum  = ca * cb + (ac ? accv : 0);
      lo   = sg ? -(one << (aw - 1)) : 0;
      hi   = sg ? (one << (aw - 1)) - 1 : mask;
      ovf  = (sum < lo) || (sum > hi);
      if (ovf && CSAT[k] != 0) sum = (sum < lo) ? lo : hi;
      macc[k] = sum & mask;
      return {ovf, 32'(macc[k])};
   endfunction

   task automatic check_outputs();
      logic [4:0] ovs;
      ovs = {ov4, ov3, ov2, ov1, ov0};
      if (ov0) begin
         chk("out_valid_without_beat", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            for (int k = 0; k < 5; k++) begin
               n_cmp++;
               if (act[k] !== exp_q[0][k] || ovs[k] !== 1'b1) begin
                  n_bad++;
                  $display("FAIL beat inst%0d: got valid=%0b ovf=%0b data=0x%0h required valid=1 ovf=%0b data=0x%0h",
                           k, ovs[k], act[k][32], act[k][31:0], exp_q[0][k][32], exp_q[0][k][31:0]);
               end
            end
         end
      end else begin
         chk("out_valid_lockstep", ovs, 0);
      end
   endtask

   task automatic cycle(input bit iv, input logic [15:0] av, input logic [15:0] bv, input bit sg,
                        input bit ac, input bit ordy, output bit accepted);
      beat_t e;
      @(negedge clk);
      check_outputs();
      in_valid  = iv;
      a         = av;
      b         = bv;
      signed_in = sg;
      acc_in    = ac;
      out_ready = ordy;
      #1;
      chk("in_ready", rdy0, !ov0 || ordy);
      chk("in_ready_lockstep", {rdy4, rdy3, rdy2, rdy1}, {4{!ov0 || ordy}});
      accepted = iv && rdy0;
      if (accepted) begin
         for (int k = 0; k < 5; k++) e[k] = model_step(k, av, bv, sg, ac);
         exp_q.push_back(e);
      end
      if (ov0 && ordy && exp_q.size() > 0) begin
         got_q.push_back(act);
         void'(exp_q.pop_front());
      end
   endtask

   task automatic idle();
      cycle(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, ok_b);
   endtask

   task automatic beat(input logic [15:0] av, input logic [15:0] bv, input bit sg, input bit ac);
      cycle(1'b1, av, bv, sg, ac, 1'b1, ok_b);
      chk("beat_accepted", ok_b, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle();
      chk("drain_timeout_left", exp_q.size(), 0);
      idle();
      idle();
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("async_rst_out_valid", ov0, 0);
      chk("async_rst_out_data", od0, 0);
      chk("async_rst_out_ovf", of0, 0);
      exp_q.delete();
      got_q.delete();
      for (int k = 0; k < 5; k++) macc[k] = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic longint got_data(input int i, input int k);
      return (got_q.size() > i) ? longint'(got_q[i][k][31:0]) : -1;
   endfunction

   function automatic longint got_ovf(input int i, input int k);
      return (got_q.size() > i) ? longint'(got_q[i][k][32]) : -1;
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h007F;
         3:       return 16'hFF80;
         4:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int i;
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      signed_in = 1'b0;
      acc_in    = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) macc[k] = 0;

      repeat (3) @(negedge clk);
      chk("reset_out_valid", ov0, 0);
      chk("reset_out_data", od0, 0);
      chk("reset_out_ovf", of0, 0);
      chk("reset_out_data_w16", od4, 0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", rdy0, 1);

      // Unsigned 255*255 load, latency of exactly three cycles.
      got_q.delete();
      beat(16'd255, 16'd255, 1'b0, 1'b0);
      idle();
      chk("t1_valid_cycle1", ov0, 0);
      idle();
      chk("t1_valid_cycle2", ov0, 0);
      idle();
      chk("t1_valid_cycle3", ov0, 1);
      chk("t1_data", od0, 65025);
      chk("t1_ovf", of0, 0);
      drain();

      // Signed chain.
      got_q.delete();
      beat(16'hFF80, 16'hFF80, 1'b1, 1'b0);
      beat(16'hFFFD, 16'd5, 1'b1, 1'b1);
      beat(16'd7, 16'hFFFF, 1'b1, 1'b1);
      drain();
      chk("t2_beat1", got_data(0, 0), 16384);
      chk("t2_beat2", got_data(1, 0), 16369);
      chk("t2_beat3", got_data(2, 0), 16362);

      // Saturate (u1) versus wrap (u2) with a 16-bit signed accumulator.
      got_q.delete();
      beat(16'd127, 16'd127, 1'b1, 1'b0);
      repeat (3) beat(16'd127, 16'd127, 1'b1, 1'b1);
      drain();
      chk("t4_sat_1", got_data(0, 1), 16129);
      chk("t4_sat_1_ovf", got_ovf(0, 1), 0);
      chk("t4_sat_2", got_data(1, 1), 32258);
      chk("t4_sat_2_ovf", got_ovf(1, 1), 0);
      chk("t4_sat_3", got_data(2, 1), 32767);
      chk("t4_sat_3_ovf", got_ovf(2, 1), 1);
      chk("t4_sat_4", got_data(3, 1), 32767);
      chk("t4_sat_4_ovf", got_ovf(3, 1), 1);
      chk("t4_wrap_3", got_data(2, 2), 16'hBD03);
      chk("t4_wrap_3_ovf", got_ovf(2, 2), 1);
      chk("t4_wrap_4", got_data(3, 2), 16'hFC04);
      chk("t4_wrap_4_ovf", got_ovf(3, 2), 0);
      chk("t4_wide_3", got_data(2, 0), 48387);

      // Backpressure: out_ready low for four cycles once the first result shows.
      got_q.delete();
      t = 0;
      i = 1;
      while (i <= 5 && t < 40) begin
         cycle(1'b1, 16'(i), 16'(i), 1'b0, 1'b0, !(t >= 3 && t < 7), ok_b);
         if (t >= 3 && t < 7) chk("t3_stall_in_ready", rdy0, 0);
         if (ok_b) i++;
         t++;
      end
      chk("t3_all_sent", i, 6);
      drain();
      chk("t3_count", got_q.size(), 5);
      for (int k = 0; k < 5; k++) chk("t3_order", got_data(k, 0), (k + 1) * (k + 1));

      // Asynchronous reset with two beats in flight.
      beat(16'd3, 16'd4, 1'b0, 1'b0);
      beat(16'd5, 16'd6, 1'b0, 1'b0);
      async_reset();
      repeat (6) idle();
      chk("t5_nothing_emitted", got_q.size(), 0);
      beat(16'd9, 16'd9, 1'b0, 1'b1);
      drain();
      chk("t5_reload", got_data(0, 0), 81);

      // Randomised traffic across all instances, with one reset in the middle.
      for (int it = 0; it < 3000; it++) begin
         if (it == 1500) async_reset();
         cycle($urandom_range(0, 9) < 7, pick(), pick(), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, ok_b);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
